// File: rtl/param_interval_timer.sv
// Avalon-MM interval timer on a 16-bit bus: software-writable period, tick prescaler,
// snapshot capture, timeout/missed-timeout status and one level IRQ.
module param_interval_timer #(
    parameter int          COUNTER_WIDTH  = 32,
    parameter logic [63:0] DEFAULT_PERIOD = 64'd999,
    parameter int          PRESCALE       = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam int NW = COUNTER_WIDTH / 16;
    localparam logic [COUNTER_WIDTH-1:0] DEF_PERIOD = DEFAULT_PERIOD[COUNTER_WIDTH-1:0];
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE    = COUNTER_WIDTH'(1);
    localparam logic [15:0]              PS_LAST    = 16'(PRESCALE - 1);

    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d;
    logic [COUNTER_WIDTH-1:0] snap_q, snap_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] readdata_q, readdata_d;
    logic        to_q, to_d;
    logic        miss_q, miss_d;
    logic        run_q, run_d;
    logic        force_reload_q, force_reload_d;
    logic        armed_q, armed_d;

    logic wr, status_wr, ctrl_wr, start, stop, period_wr, snap_wr;
    logic cont, tick, cnt_zero, timeout, hold_zero;

    // Bus decode; words beyond the configured width are neither written nor captured.
    always_comb begin
        wr        = chipselect & ~write_n;
        status_wr = wr & (address == 4'd0);
        ctrl_wr   = wr & (address == 4'd1);
        start     = ctrl_wr & writedata[2];
        stop      = ctrl_wr & writedata[3];
        period_wr = 1'b0;
        snap_wr   = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (wr && address == 4'(2 + k)) period_wr = 1'b1;
            if (wr && address == 4'(6 + k)) snap_wr   = 1'b1;
        end
    end

    always_comb begin
        cont      = ctrl_q[1];
        tick      = run_q & (presc_q == PS_LAST);
        cnt_zero  = (counter_q == '0);
        timeout   = cnt_zero & armed_q;
        // A one-shot expiry parks the counter at zero instead of reloading.
        hold_zero = timeout & ~cont;
    end

    // armed_q marks that the counter just left zero (or reloaded from it), so a
    // zero period still yields a timeout on every tick.
    always_comb begin
        counter_d = counter_q;
        armed_d   = ~cnt_zero;
        if (force_reload_q) begin
            counter_d = period_q;
        end else if (tick && !hold_zero) begin
            if (cnt_zero) begin
                counter_d = period_q;
                armed_d   = 1'b1;
            end else begin
                counter_d = counter_q - CNT_ONE;
            end
        end
    end

    always_comb begin
        period_d = period_q;
        for (int k = 0; k < NW; k++) begin
            if (wr && address == 4'(2 + k)) period_d[16*k +: 16] = writedata;
        end
        force_reload_d = period_wr;
        snap_d         = snap_wr ? counter_q : snap_q;
        ctrl_d         = ctrl_wr ? writedata[3:0] : ctrl_q;
    end

    always_comb begin
        presc_d = presc_q;
        if (start || period_wr || force_reload_q) presc_d = '0;
        else if (run_q)                           presc_d = tick ? 16'd0 : presc_q + 16'd1;

        run_d = run_q;
        if (stop || force_reload_q || hold_zero) run_d = 1'b0;
        if (start)                               run_d = 1'b1;

        to_d   = to_q;
        miss_d = miss_q;
        if (status_wr) begin
            to_d   = 1'b0;
            miss_d = 1'b0;
        end
        // A timeout beats a coincident status write: TO stays set, MISS is cleared.
        if (timeout) begin
            to_d   = 1'b1;
            miss_d = status_wr ? 1'b0 : (to_q | miss_q);
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            4'd0: readdata_d = {13'd0, miss_q, run_q, to_q};
            4'd1: readdata_d = {12'd0, ctrl_q};
            default: begin
                for (int k = 0; k < NW; k++) begin
                    if (address == 4'(2 + k)) readdata_d = period_q[16*k +: 16];
                    if (address == 4'(6 + k)) readdata_d = snap_q[16*k +: 16];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            counter_q      <= DEF_PERIOD;
            period_q       <= DEF_PERIOD;
            snap_q         <= '0;
            ctrl_q         <= '0;
            presc_q        <= '0;
            readdata_q     <= '0;
            to_q           <= 1'b0;
            miss_q         <= 1'b0;
            run_q          <= 1'b0;
            force_reload_q <= 1'b0;
            armed_q        <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            period_q       <= period_d;
            snap_q         <= snap_d;
            ctrl_q         <= ctrl_d;
            presc_q        <= presc_d;
            readdata_q     <= readdata_d;
            to_q           <= to_d;
            miss_q         <= miss_d;
            run_q          <= run_d;
            force_reload_q <= force_reload_d;
            armed_q        <= armed_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = to_q & ctrl_q[0];

endmodule
